led_breath_pwm: RTL



---
 rtl/led_breath_pwm.sv | 131 +++++++++++++
 1 files changed

// File: rtl/led_breath_pwm.sv
// Breathing-LED PWM generator: prescaled PWM counter compared against a duty register
// that a four-phase FSM ramps up, holds, ramps down and holds again; all outputs registered.
module led_breath_pwm #(
  parameter int CLK_DIV      = 4,
  parameter int PWM_BITS     = 4,
  parameter int HOLD_PERIODS = 2
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  input  logic                iEN,
  output logic                oLED,
  output logic [PWM_BITS-1:0] oDUTY,
  output logic [1:0]          oPHASE,
  output logic                oCYCLE_DONE
);

  localparam int PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HOLD_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(CLK_DIV - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);
  // P-1: last PWM count value and the duty at which the ramps turn around
  localparam logic [PWM_BITS-1:0] CNT_LAST  = {{(PWM_BITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    HOLD_LO = 2'd0,
    RISE    = 2'd1,
    HOLD_HI = 2'd2,
    FALL    = 2'd3
  } phase_t;

  logic [PRE_W-1:0]    prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] duty_nxt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [HOLD_W-1:0]   hold_nxt;
  phase_t              phase;
  phase_t              phase_nxt;
  logic                done_nxt;
  logic                tick;
  logic                period_end;
  logic                led;
  logic                cycle_done;

  assign tick       = iEN && (prescaler == PRE_LAST);
  assign period_end = tick && (pwm_cnt == CNT_LAST);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else begin
      if (iEN) begin
        prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + 1'b1;
      end
      if (tick) begin
        pwm_cnt <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + 1'b1;
      end
    end
  end

  // FSM only advances on period_end, which already implies iEN
  always_comb begin
    phase_nxt = phase;
    duty_nxt  = duty;
    hold_nxt  = hold_cnt;
    done_nxt  = 1'b0;
    if (period_end) begin
      case (phase)
        HOLD_LO: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_nxt  = '0;
            duty_nxt  = DUTY_ONE;
            phase_nxt = RISE;
          end else begin
            hold_nxt = hold_cnt + 1'b1;
          end
        end
        RISE: begin
          duty_nxt = duty + 1'b1;
          if (duty == CNT_LAST) begin
            phase_nxt = HOLD_HI;
          end
        end
        HOLD_HI: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_nxt  = '0;
            duty_nxt  = CNT_LAST;
            phase_nxt = FALL;
          end else begin
            hold_nxt = hold_cnt + 1'b1;
          end
        end
        FALL: begin
          duty_nxt = duty - 1'b1;
          if (duty == DUTY_ONE) begin
            phase_nxt = HOLD_LO;
            done_nxt  = 1'b1;
          end
        end
        default: begin
          phase_nxt = HOLD_LO;
        end
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      phase      <= HOLD_LO;
      duty       <= '0;
      hold_cnt   <= '0;
      led        <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      phase      <= phase_nxt;
      duty       <= duty_nxt;
      hold_cnt   <= hold_nxt;
      led        <= iEN && (pwm_cnt < duty);
      cycle_done <= done_nxt;
    end
  end

  assign oLED        = led;
  assign oDUTY       = duty;
  assign oPHASE      = phase;
  assign oCYCLE_DONE = cycle_done;

endmodule
